// File: rtl/mux4_1_arbiter.sv
// Round-robin arbiter for four requesters sharing one resource behind a 4:1 select mux.
// Optional hold watchdog enabled by defining MUX4_1_ARBITER_HOLD_TIMEOUT_EN.
module mux4_1_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [1:0] last_owner;
  logic [1:0] winner;
  logic       found;
  logic       release_normal;
  logic       release_any;
  logic       expire;

  if (MAX_HOLD < 1) begin : g_bad_param
    $error("mux4_1_arbiter: MAX_HOLD must be >= 1");
  end

  // Scan starting just after the last owner so the previous owner ranks lowest.
  always_comb begin
    logic [1:0] cand;
    winner = last_owner;
    found  = 1'b0;
    cand   = last_owner;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner + 2'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign release_normal = done | ~req[sel];
  assign release_any    = release_normal | expire;

`ifdef MUX4_1_ARBITER_HOLD_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_cnt;

  // Hitting MAX_HOLD-1 here means this edge would be the MAX_HOLD-th held cycle.
  assign expire = (state == GRANT) && (hold_cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= (state == GRANT) && !release_normal && expire;
      if (state == GRANT)
        hold_cnt <= hold_cnt + 1'b1;
      else
        hold_cnt <= '0;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 4'b0000;
      sel        <= 2'b00;
      busy       <= 1'b0;
      last_owner <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= 4'b0001 << winner;
            sel   <= winner;
            busy  <= 1'b1;
            state <= GRANT;
          end else begin
            grant <= 4'b0000;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          // sel stays put on release so the mux output does not glitch while idle.
          if (release_any) begin
            grant      <= 4'b0000;
            busy       <= 1'b0;
            last_owner <= sel;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux4_1_arbiter.md
Name: mux4_1_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit resource, reached through the existing 4:1 select mux, between four requesters.
- Drives the mux select plus a one-hot grant vector and holds ownership until the transaction completes.
- Sits between the requesters (fetch, load/store, debug, DMA-style masters) and the shared memory/bus port.

Parameters:
- MAX_HOLD, 16, maximum cycles one owner may hold the grant (used only with the optional feature); must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request per requester; bit i = requester i; level-sensitive.
- done  input  1  shared resource signals that the current owner's transaction is complete.
- grant  output  4  one-hot grant, registered; all zero when idle.
- sel  output  2  mux select, registered; index of current or last owner.
- busy  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when the hold watchdog revokes a grant.

Behaviour:
- Reset (async, rst_n=0):
  - grant=4'b0000, sel=2'b00, busy=0, timeout=0, state=IDLE, last_owner=3.
  - last_owner=3 gives requester 0 first priority after reset.
- State IDLE:
  - If req!=0 at a rising edge, pick the winner as the first set bit scanning last_owner+1, +2, +3, +4 (mod 4).
  - On that same edge: grant=onehot(winner), sel=winner, busy=1, state goes to GRANT.
  - Latency: req sampled at edge N, grant visible after edge N (one cycle).
  - If req==0: stay in IDLE; grant=0, busy=0, sel holds its previous value so the mux output stays stable.
- State GRANT, with owner = sel:
  - Release condition at an edge: done=1, or req[owner]=0.
  - On release: grant=0, busy=0, last_owner=owner, state goes to IDLE; sel unchanged.
  - Re-arbitration therefore always takes one IDLE cycle, so there is one dead cycle between consecutive grants.
  - Non-owner req changes during GRANT are ignored; no preemption.
  - done sampled while in IDLE is ignored.
- Simultaneous events:
  - done=1 and other requests pending at the same edge: release, then arbitrate on the following edge using the updated last_owner.
  - Owner still requesting after release competes normally; it has lowest priority because it is last_owner.
- Fairness: with all four req held high and done pulsed once per grant, grant order is 0,1,2,3,0,...
- Reset mid-operation: async clear to reset values regardless of state; the pending transaction is abandoned.
- grant is always zero or one-hot; sel always equals the index of the set grant bit while busy=1.

Optional Feature:
- Macro: MUX4_1_ARBITER_HOLD_TIMEOUT_EN
- Defined:
  - A hold counter (width $clog2(MAX_HOLD+1)) clears on every grant edge and increments each cycle in GRANT.
  - If the counter reaches MAX_HOLD without a release, force a release on that edge exactly as for done.
  - timeout=1 for that one cycle only; last_owner=owner.
  - done or req drop at the same edge takes normal-release precedence, with timeout=0.
- Not defined:
  - No counter logic; timeout is tied to 0.
  - A grant lasts until done or req drop, indefinitely.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> grant=0000, sel=00, busy=0; release reset -> after first edge grant=0001, sel=00, busy=1.
- Round-robin: req=4'b1111, done pulsed one cycle after each grant -> grant sequence 0001,0010,0100,1000,0001 with one idle cycle (grant=0000) between each.
- Skip and wrap: last_owner=1, req=4'b0001 -> grant=0001, sel=00 (wrap past 2,3); then req=4'b1001 after release -> grant=1000.
- Req drop release: owner 2 granted, req[2] deasserted -> next edge grant=0000, busy=0, sel stays 10; done later while IDLE -> no effect.
- Async reset mid-grant: grant=0100, rst_n pulsed low between edges -> grant=0000, sel=00 immediately; after release, req=4'b0100 -> grant=0100 (last_owner=3 again).
- Timeout (macro defined, MAX_HOLD=4): req=4'b0010 held, done=0 -> grant released 4 cycles after grant edge, timeout=1 for exactly 1 cycle; with done=1 on that same edge -> timeout=0.
